// File: rtl/jesd_tpl_profile_pkg.sv
// Shared definitions for the JESD TPL profile controller: register map,
// descriptor field positions and the profile-switch state encoding.
package jesd_tpl_profile_pkg;

  localparam int unsigned MAX_PROFILES = 16;
  localparam int unsigned PROFILE_W    = 4;

  // up-bus word page 0x80-0xFF (byte offsets 0x0200-0x03FC)
  localparam logic [6:0]  WINDOW_PAGE  = 7'h01;
  localparam logic [13:0] ADDR_CNTRL   = 14'h0080;
  localparam logic [13:0] ADDR_STATUS  = 14'h0081;
  localparam logic [13:0] ADDR_DESC1   = 14'h0090;
  localparam logic [13:0] ADDR_DESC2   = 14'h0091;

  localparam int unsigned STATUS_SWITCH_ERR_BIT = 8;
  localparam int unsigned DESC_F_LSB  = 24;
  localparam int unsigned DESC_S_LSB  = 16;
  localparam int unsigned DESC_L_LSB  = 8;
  localparam int unsigned DESC_M_LSB  = 0;
  localparam int unsigned DESC_NP_LSB = 8;
  localparam int unsigned DESC_N_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } profile_state_t;

  function automatic logic [7:0] profile_byte(
    input logic [MAX_PROFILES*8-1:0] tbl,
    input logic [PROFILE_W-1:0]      idx
  );
    return tbl[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/jesd_tpl_profile_fsm.sv
// Profile-switch sequencer: CNTRL selection register, req/ack handshake with the
// TPL datapath and the active-profile register. Timeout under JESD_TPL_PROFILE_TIMEOUT_EN.
module jesd_tpl_profile_fsm
  import jesd_tpl_profile_pkg::*;
#(
  parameter int unsigned NUM_PROFILES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cntrl_wr,
  input  logic [PROFILE_W-1:0] cntrl_data,
  input  logic                 profile_switch_ack,
  output logic [PROFILE_W-1:0] profile_sel,
  output logic [PROFILE_W-1:0] profile_active,
  output logic [PROFILE_W-1:0] profile_next,
  output logic                 profile_switch_req,
  output logic                 profile_busy,
  output logic                 switch_err
);

  profile_state_t state, state_nxt;
  logic sel_ok;
  logic start;
  logic ack_hit;
  logic timeout;

  // A CNTRL write is only accepted in IDLE and for an implemented profile.
  assign sel_ok  = cntrl_wr && (state == ST_IDLE) &&
                   ({{(32-PROFILE_W){1'b0}}, cntrl_data} < NUM_PROFILES);
  assign start   = sel_ok && (cntrl_data != profile_active);
  assign ack_hit = (state == ST_REQ) && profile_switch_ack;

`ifdef JESD_TPL_PROFILE_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] to_cnt;

  assign timeout = (state == ST_REQ) && !profile_switch_ack &&
                   (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt     <= '0;
      switch_err <= 1'b0;
    end else begin
      to_cnt <= (state == ST_REQ) ? to_cnt + CNT_W'(1) : '0;
      if (sel_ok)
        switch_err <= 1'b0;
      else if (timeout)
        switch_err <= 1'b1;
    end
  end
`else
  assign timeout    = 1'b0;
  assign switch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_REQ;
      ST_REQ: begin
        if (profile_switch_ack)
          state_nxt = ST_DONE;
        else if (timeout)
          state_nxt = ST_IDLE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    profile_switch_req = (state == ST_REQ);
    profile_busy       = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      profile_sel    <= '0;
      profile_next   <= '0;
      profile_active <= '0;
    end else begin
      if (sel_ok)
        profile_sel <= cntrl_data;
      else if (timeout)
        profile_sel <= profile_active;
      if (start)
        profile_next <= cntrl_data;
      if (ack_hit)
        profile_active <= profile_next;
    end
  end

endmodule

// File: rtl/jesd_tpl_profile_ctrl.sv
// up_tpl_common register slave and profile-switch controller for the JESD TPL.
// Optional ack timeout and STATUS.SWITCH_ERR enabled by JESD_TPL_PROFILE_TIMEOUT_EN.
module jesd_tpl_profile_ctrl
  import jesd_tpl_profile_pkg::*;
#(
  parameter int unsigned                   NUM_PROFILES   = 1,
  parameter logic [MAX_PROFILES*8-1:0]     PROFILES_F     = {MAX_PROFILES{8'd1}},
  parameter logic [MAX_PROFILES*8-1:0]     PROFILES_S     = {MAX_PROFILES{8'd1}},
  parameter logic [MAX_PROFILES*8-1:0]     PROFILES_L     = {MAX_PROFILES{8'd1}},
  parameter logic [MAX_PROFILES*8-1:0]     PROFILES_M     = {MAX_PROFILES{8'd1}},
  parameter logic [MAX_PROFILES*8-1:0]     PROFILES_N     = {MAX_PROFILES{8'd16}},
  parameter logic [MAX_PROFILES*8-1:0]     PROFILES_NP    = {MAX_PROFILES{8'd16}},
  parameter int unsigned                   TIMEOUT_CYCLES = 1024
) (
  input  logic        up_clk,
  input  logic        up_rstn,
  input  logic        up_wreq,
  input  logic [13:0] up_waddr,
  input  logic [31:0] up_wdata,
  output logic        up_wack,
  input  logic        up_rreq,
  input  logic [13:0] up_raddr,
  output logic [31:0] up_rdata,
  output logic        up_rack,
  output logic [3:0]  profile_active,
  output logic [3:0]  profile_next,
  output logic        profile_switch_req,
  input  logic        profile_switch_ack,
  output logic        profile_busy
);

  localparam logic [PROFILE_W-1:0] PROFILE_NUM = PROFILE_W'(NUM_PROFILES - 1);

  logic                 wr_win;
  logic                 rd_win;
  logic                 cntrl_wr;
  logic [PROFILE_W-1:0] cntrl_data;
  logic [PROFILE_W-1:0] profile_sel;
  logic                 switch_err;
  logic [31:0]          rd_mux;
  logic                 unused_wdata;

  assign wr_win       = up_wreq && (up_waddr[13:7] == WINDOW_PAGE);
  assign rd_win       = up_rreq && (up_raddr[13:7] == WINDOW_PAGE);
  assign unused_wdata = ^up_wdata[31:PROFILE_W];

  // CNTRL writes are staged one cycle so the FSM acts on the acked write.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      up_wack    <= 1'b0;
      cntrl_wr   <= 1'b0;
      cntrl_data <= '0;
    end else begin
      up_wack    <= wr_win;
      cntrl_wr   <= wr_win && (up_waddr == ADDR_CNTRL);
      cntrl_data <= up_wdata[PROFILE_W-1:0];
    end
  end

  jesd_tpl_profile_fsm #(
    .NUM_PROFILES   (NUM_PROFILES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .clk                (up_clk),
    .rst_n              (up_rstn),
    .cntrl_wr           (cntrl_wr),
    .cntrl_data         (cntrl_data),
    .profile_switch_ack (profile_switch_ack),
    .profile_sel        (profile_sel),
    .profile_active     (profile_active),
    .profile_next       (profile_next),
    .profile_switch_req (profile_switch_req),
    .profile_busy       (profile_busy),
    .switch_err         (switch_err)
  );

  always_comb begin
    rd_mux = '0;
    case (up_raddr)
      ADDR_CNTRL:  rd_mux[PROFILE_W-1:0] = profile_sel;
      ADDR_STATUS: begin
        rd_mux[PROFILE_W-1:0]         = PROFILE_NUM;
        rd_mux[STATUS_SWITCH_ERR_BIT] = switch_err;
      end
      ADDR_DESC1: begin
        rd_mux[DESC_F_LSB +: 8] = profile_byte(PROFILES_F, profile_active);
        rd_mux[DESC_S_LSB +: 8] = profile_byte(PROFILES_S, profile_active);
        rd_mux[DESC_L_LSB +: 8] = profile_byte(PROFILES_L, profile_active);
        rd_mux[DESC_M_LSB +: 8] = profile_byte(PROFILES_M, profile_active);
      end
      ADDR_DESC2: begin
        rd_mux[DESC_NP_LSB +: 8] = profile_byte(PROFILES_NP, profile_active);
        rd_mux[DESC_N_LSB +: 8]  = profile_byte(PROFILES_N, profile_active);
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      up_rack  <= 1'b0;
      up_rdata <= '0;
    end else begin
      up_rack  <= rd_win;
      up_rdata <= rd_win ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_jesd_tpl_profile_ctrl.sv
// Scoreboard bench for jesd_tpl_profile_ctrl: randomized register traffic and
// profile switches checked against a table-driven model of the register map.
module tb_jesd_tpl_profile_ctrl;

  localparam int unsigned NP = 4;
  localparam int unsigned TO = 16;
  localparam logic [127:0] PF  = {{12{8'd1}},  8'd8,  8'd4,  8'd2,  8'd1};
  localparam logic [127:0] PS  = {{12{8'd1}},  8'd1,  8'd2,  8'd1,  8'd1};
  localparam logic [127:0] PL  = {{12{8'd1}},  8'd8,  8'd1,  8'd2,  8'd4};
  localparam logic [127:0] PM  = {{12{8'd1}},  8'd1,  8'd8,  8'd4,  8'd2};
  localparam logic [127:0] PN  = {{12{8'd16}}, 8'd16, 8'd14, 8'd12, 8'd16};
  localparam logic [127:0] PNP = {{12{8'd16}}, 8'd12, 8'd16, 8'd16, 8'd16};

  logic        up_clk = 1'b0;
  logic        up_rstn = 1'b0;
  logic        up_wreq = 1'b0;
  logic [13:0] up_waddr = '0;
  logic [31:0] up_wdata = '0;
  logic        up_wack;
  logic        up_rreq = 1'b0;
  logic [13:0] up_raddr = '0;
  logic [31:0] up_rdata;
  logic        up_rack;
  logic [3:0]  profile_active;
  logic [3:0]  profile_next;
  logic        profile_switch_req;
  logic        profile_switch_ack = 1'b0;
  logic        profile_busy;

  always #5 up_clk = ~up_clk;

  jesd_tpl_profile_ctrl #(
    .NUM_PROFILES   (NP),
    .PROFILES_F     (PF),
    .PROFILES_S     (PS),
    .PROFILES_L     (PL),
    .PROFILES_M     (PM),
    .PROFILES_N     (PN),
    .PROFILES_NP    (PNP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .up_clk             (up_clk),
    .up_rstn            (up_rstn),
    .up_wreq            (up_wreq),
    .up_waddr           (up_waddr),
    .up_wdata           (up_wdata),
    .up_wack            (up_wack),
    .up_rreq            (up_rreq),
    .up_raddr           (up_raddr),
    .up_rdata           (up_rdata),
    .up_rack            (up_rack),
    .profile_active     (profile_active),
    .profile_next       (profile_next),
    .profile_switch_req (profile_switch_req),
    .profile_switch_ack (profile_switch_ack),
    .profile_busy       (profile_busy)
  );

  // Reference tables, profile index -> field value
  int tf[4]  = '{1, 2, 4, 8};
  int ts[4]  = '{1, 1, 2, 1};
  int tl[4]  = '{4, 2, 1, 8};
  int tm[4]  = '{2, 4, 8, 1};
  int tn[4]  = '{16, 12, 14, 16};
  int tnp[4] = '{16, 16, 16, 12};

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          m_active = 0;
  int          m_cntrl  = 0;
  bit          m_err    = 1'b0;
  logic [31:0] rd_q[$];
  int          act_q[$];
  bit          wack_exp = 1'b0;
  bit          rack_exp = 1'b0;
  logic [3:0]  seen_active = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
    end
  endfunction

  function automatic bit in_window(input logic [13:0] a);
    return (a >= 14'h0080) && (a <= 14'h00FF);
  endfunction

  function automatic logic [31:0] model_read(input logic [13:0] a);
    case (a)
      14'h0080: return 32'(m_cntrl);
      14'h0081: return 32'((m_err ? 256 : 0) + int'(NP) - 1);
      14'h0090: return 32'((tf[m_active] << 24) | (ts[m_active] << 16) |
                           (tl[m_active] << 8) | tm[m_active]);
      14'h0091: return 32'((tnp[m_active] << 8) | tn[m_active]);
      default:  return 32'd0;
    endcase
  endfunction

  // Any access in the window is acked on the following cycle
  always @(posedge up_clk) begin
    wack_exp = up_rstn && up_wreq && in_window(up_waddr);
    rack_exp = up_rstn && up_rreq && in_window(up_raddr);
  end

  always @(negedge up_clk) begin
    chk("wack", up_wack, wack_exp);
    chk("rack", up_rack, rack_exp);
    if (up_rack) begin
      if (rd_q.size() == 0)
        chk("rdata_unexpected", up_rdata, 32'hDEAD_BEEF);
      else
        chk("rdata", up_rdata, rd_q.pop_front());
    end else begin
      chk("rdata_idle_zero", up_rdata, 32'd0);
    end
    if (profile_active != seen_active) begin
      if (act_q.size() == 0)
        chk("active_unexpected_change", 32'(profile_active), 32'(seen_active));
      else
        chk("profile_active", 32'(profile_active), 32'(act_q.pop_front()));
      seen_active = profile_active;
    end
  end

  task automatic tick();
    @(posedge up_clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    up_wreq  = 1'b1;
    up_waddr = a;
    up_wdata = d;
    tick();
    up_wreq  = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a);
    if (in_window(a))
      rd_q.push_back(model_read(a));
    up_rreq  = 1'b1;
    up_raddr = a;
    tick();
    up_rreq  = 1'b0;
  endtask

  // CNTRL write from IDLE; d = cycles req is held before ack is given
  task automatic cntrl(input int v, input int d, input bit inject);
    bit sw;
    sw = (v < int'(NP)) && (v != m_active);
    if (v < int'(NP)) begin
      m_cntrl = v;
      m_err   = 1'b0;
    end
    wr(14'h0080, 32'(v));
    if (!sw) begin
      tick();
      return;
    end
    act_q.push_back(v);
    chk("req_low_with_wack", 32'(profile_switch_req), 32'd0);
    tick();
    chk("req_rise", 32'(profile_switch_req), 32'd1);
    chk("busy_in_req", 32'(profile_busy), 32'd1);
    chk("profile_next", 32'(profile_next), 32'(v));
    for (int i = 1; i < d; i++) begin
      if (inject && i == 1) begin
        up_wreq  = 1'b1;
        up_waddr = 14'h0080;
        up_wdata = 32'((v + 1) % int'(NP));
      end
      tick();
      up_wreq = 1'b0;
      chk("req_held", 32'(profile_switch_req), 32'd1);
    end
    profile_switch_ack = 1'b1;
    tick();
    profile_switch_ack = 1'b0;
    m_active = v;
    chk("req_drop", 32'(profile_switch_req), 32'd0);
    chk("busy_done", 32'(profile_busy), 32'd1);
    chk("active_after_ack", 32'(profile_active), 32'(v));
    tick();
    chk("busy_drop", 32'(profile_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] mapped[4];
    int v;
    int n;
    mapped = '{14'h0080, 14'h0081, 14'h0090, 14'h0091};

    #1;
    chk("reset_wack", 32'(up_wack), 32'd0);
    chk("reset_rack", 32'(up_rack), 32'd0);
    chk("reset_req", 32'(profile_switch_req), 32'd0);
    chk("reset_busy", 32'(profile_busy), 32'd0);
    chk("reset_active", 32'(profile_active), 32'd0);
    chk("reset_next", 32'(profile_next), 32'd0);
    repeat (3) tick();
    up_rstn = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) rd(mapped[i]);

    cntrl(2, 5, 1'b0);
    rd(14'h0090);
    rd(14'h0091);
    rd(14'h0080);

    cntrl(7, 1, 1'b0);
    rd(14'h0080);

    cntrl(3, 5, 1'b1);
    rd(14'h0080);
    cntrl(3, 1, 1'b0);
    rd(14'h0080);

    wr(14'h0180, 32'd1);
    tick();
    rd(14'h0080);
    rd(14'h0100);
    rd(14'h00A5);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: rd(mapped[$urandom_range(0, 3)]);
        1: rd(14'(14'h0080 + $urandom_range(0, 127)));
        2: rd(14'($urandom_range(0, 16383)));
        default: cntrl(int'($urandom_range(0, 5)), int'($urandom_range(1, 6)),
                       1'($urandom_range(0, 1)));
      endcase
    end

`ifdef JESD_TPL_PROFILE_TIMEOUT_EN
    v = (m_active + 1) % int'(NP);
    wr(14'h0080, 32'(v));
    tick();
    n = 0;
    while (profile_switch_req && n < 100) begin
      n++;
      tick();
    end
    chk("timeout_req_cycles", 32'(n), 32'(TO));
    chk("timeout_busy", 32'(profile_busy), 32'd0);
    m_cntrl = m_active;
    m_err   = 1'b1;
    rd(14'h0081);
    rd(14'h0080);
    cntrl(m_active, 1, 1'b0);
    rd(14'h0081);
`endif

    // Reset in the middle of a switch
    v = (m_active + 1) % int'(NP);
    m_cntrl = v;
    wr(14'h0080, 32'(v));
    tick();
    tick();
    chk("req_before_reset", 32'(profile_switch_req), 32'd1);
    if (m_active != 0) act_q.push_back(0);
    #2 up_rstn = 1'b0;
    #1;
    chk("rst_req", 32'(profile_switch_req), 32'd0);
    chk("rst_busy", 32'(profile_busy), 32'd0);
    chk("rst_active", 32'(profile_active), 32'd0);
    m_active = 0;
    m_cntrl  = 0;
    m_err    = 1'b0;
    tick();
    tick();
    up_rstn = 1'b1;
    tick();
    rd(14'h0080);
    rd(14'h0090);

    // Simultaneous read and (ignored, out-of-range) CNTRL write
    rd_q.push_back(model_read(14'h0081));
    up_wreq  = 1'b1;
    up_waddr = 14'h0080;
    up_wdata = 32'd5;
    up_rreq  = 1'b1;
    up_raddr = 14'h0081;
    tick();
    up_wreq = 1'b0;
    up_rreq = 1'b0;
    tick();
    rd(14'h0080);
    chk("no_switch_after_bad_write", 32'(profile_busy), 32'd0);

    repeat (4) tick();
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("active_queue_drained", 32'(act_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
